// File: rtl/key_event_decoder_pkg.sv
// Shared state encodings and default timing constants for the key event decoder.
package key_event_decoder_pkg;

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        PRESSED      = 3'd1,
        LONG_HELD    = 3'd2,
        WAIT_DBL     = 3'd3,
        SECOND_PRESS = 3'd4
    } key_state_t;

    localparam int DEF_TICK_CNT = 50000;
    localparam int DEF_LONG_MS  = 1000;
    localparam int DEF_DBL_MS   = 300;
    localparam int DEF_REP_MS   = 200;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/key_event_decoder_if.sv
// Key flag inputs and gesture outputs of one decoder instance.
interface key_event_if;
    logic key_p_flag;
    logic key_r_flag;
    logic short_press;
    logic double_click;
    logic long_press;
    logic repeat_pulse;
    logic key_held;

    modport master (
        output key_p_flag, key_r_flag,
        input  short_press, double_click, long_press, repeat_pulse, key_held
    );

    modport slave (
        input  key_p_flag, key_r_flag,
        output short_press, double_click, long_press, repeat_pulse, key_held
    );
endinterface

// File: rtl/key_event_decoder_ms_tick_gen.sv
// Free-running 1 ms prescaler with synchronous clear; tick marks the last cycle of each ms.
module ms_tick_gen #(
    parameter int TICK_CNT = 50000
) (
    input  logic sys_clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);
    localparam int W = (TICK_CNT > 1) ? $clog2(TICK_CNT) : 1;

    logic [W-1:0] prescaler;

    assign tick = (prescaler == W'(TICK_CNT - 1));

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            prescaler <= '0;
        end else if (clr || tick) begin
            prescaler <= '0;
        end else begin
            prescaler <= prescaler + 1'b1;
        end
    end
endmodule

// File: rtl/key_event_decoder.sv
// Classifies debounced press/release flags into short, double, long and repeat events.
module key_event_decoder
    import key_event_decoder_pkg::*;
#(
    parameter int TICK_CNT = DEF_TICK_CNT,
    parameter int LONG_MS  = DEF_LONG_MS,
    parameter int DBL_MS   = DEF_DBL_MS,
    parameter int REP_MS   = DEF_REP_MS
) (
    input  logic           sys_clk,
    input  logic           rst_n,
    key_event_if.slave     bus
);
    localparam int MS_MAX = max3(LONG_MS, DBL_MS, REP_MS);

    key_state_t  state, state_next;
    logic [15:0] ms_cnt;
    logic        tick, trans, rep_clr;
    logic        p, r;
    logic        short_next, dbl_next, long_next, rep_next;

    // Simultaneous press and release cancel each other out.
    assign p = bus.key_p_flag & ~bus.key_r_flag;
    assign r = bus.key_r_flag & ~bus.key_p_flag;

    ms_tick_gen #(.TICK_CNT(TICK_CNT)) u_tick (
        .sys_clk (sys_clk),
        .rst_n   (rst_n),
        .clr     (trans),
        .tick    (tick)
    );

    always_comb begin
        state_next = state;
        short_next = 1'b0;
        dbl_next   = 1'b0;
        long_next  = 1'b0;
        rep_next   = 1'b0;
        rep_clr    = 1'b0;
        case (state)
            IDLE: begin
                if (p) state_next = PRESSED;
            end
            PRESSED: begin
                if (r) begin
                    state_next = WAIT_DBL;
                end else if (tick && ms_cnt == 16'(LONG_MS - 1)) begin
                    state_next = LONG_HELD;
                    long_next  = 1'b1;
                end
            end
            LONG_HELD: begin
                if (r) begin
                    state_next = IDLE;
                end else if (tick && ms_cnt == 16'(REP_MS - 1)) begin
                    rep_next = 1'b1;
                    rep_clr  = 1'b1;
                end
            end
            WAIT_DBL: begin
                if (p) begin
                    state_next = SECOND_PRESS;
                end else if (tick && ms_cnt == 16'(DBL_MS - 1)) begin
                    state_next = IDLE;
                    short_next = 1'b1;
                end
            end
            SECOND_PRESS: begin
                if (r) begin
                    state_next = IDLE;
                    dbl_next   = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign trans = (state_next != state);

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            ms_cnt           <= '0;
            bus.short_press  <= 1'b0;
            bus.double_click <= 1'b0;
            bus.long_press   <= 1'b0;
            bus.repeat_pulse <= 1'b0;
            bus.key_held     <= 1'b0;
        end else begin
            state            <= state_next;
            bus.short_press  <= short_next;
            bus.double_click <= dbl_next;
            bus.long_press   <= long_next;
            bus.repeat_pulse <= rep_next;
            bus.key_held     <= (state_next == PRESSED) || (state_next == LONG_HELD) ||
                                (state_next == SECOND_PRESS);
            // Saturation keeps idle and second-press dwell from running the counter away.
            if (trans || rep_clr) begin
                ms_cnt <= '0;
            end else if (tick && ms_cnt < 16'(MS_MAX - 1)) begin
                ms_cnt <= ms_cnt + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_key_event_decoder.sv
// Directed gesture scenarios for key_event_decoder with TICK_CNT=4, LONG_MS=5, DBL_MS=3, REP_MS=2.
module tb_key_event_decoder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    key_event_if bus();

    key_event_decoder #(
        .TICK_CNT (4),
        .LONG_MS  (5),
        .DBL_MS   (3),
        .REP_MS   (2)
    ) dut (
        .sys_clk (clk),
        .rst_n   (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Event kinds: 0 none, 1 press, 2 release, 3 both flags together.
    typedef struct packed {
        logic [3:0][7:0] ev_cyc;
        logic [3:0][1:0] ev_kind;
        int len;
        int e_short;
        int e_dbl;
        int e_long;
        int e_rep_n;
        int e_rep_first;
        int e_rep_last;
        int e_fall;
    } vec_t;

    function automatic vec_t mk(input int c0, k0, c1, k1, c2, k2, c3, k3,
                                input int len, es, ed, el, rn, rf, rl, fall);
        vec_t v;
        v.ev_cyc[0] = 8'(c0); v.ev_kind[0] = 2'(k0);
        v.ev_cyc[1] = 8'(c1); v.ev_kind[1] = 2'(k1);
        v.ev_cyc[2] = 8'(c2); v.ev_kind[2] = 2'(k2);
        v.ev_cyc[3] = 8'(c3); v.ev_kind[3] = 2'(k3);
        v.len = len; v.e_short = es; v.e_dbl = ed; v.e_long = el;
        v.e_rep_n = rn; v.e_rep_first = rf; v.e_rep_last = rl; v.e_fall = fall;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        bus.key_p_flag = 1'b0;
        bus.key_r_flag = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic int outs_word();
        return {27'd0, bus.short_press, bus.double_click, bus.long_press,
                bus.repeat_pulse, bus.key_held};
    endfunction

    task automatic run_vec(input vec_t v, input int idx);
        int n_s, n_d, n_l, n_r, c_s, c_d, c_l, r_first, r_last, fall;
        logic prev_held;
        n_s = 0; n_d = 0; n_l = 0; n_r = 0;
        c_s = -1; c_d = -1; c_l = -1; r_first = -1; r_last = -1; fall = -1;
        prev_held = 1'b0;
        do_reset();
        for (int c = 0; c < v.len; c++) begin
            @(negedge clk);
            bus.key_p_flag = 1'b0;
            bus.key_r_flag = 1'b0;
            for (int k = 0; k < 4; k++) begin
                if (v.ev_kind[k] != 2'd0 && int'(v.ev_cyc[k]) == c) begin
                    bus.key_p_flag = v.ev_kind[k][0];
                    bus.key_r_flag = v.ev_kind[k][1];
                end
            end
            if (c == 0) chk($sformatf("v%0d reset_outs", idx), outs_word(), 0);
            if (bus.short_press)  begin n_s++; if (c_s < 0) c_s = c; end
            if (bus.double_click) begin n_d++; if (c_d < 0) c_d = c; end
            if (bus.long_press)   begin n_l++; if (c_l < 0) c_l = c; end
            if (bus.repeat_pulse) begin n_r++; if (r_first < 0) r_first = c; r_last = c; end
            if (prev_held && !bus.key_held) fall = c;
            prev_held = bus.key_held;
        end
        @(negedge clk);
        bus.key_p_flag = 1'b0;
        bus.key_r_flag = 1'b0;
        chk($sformatf("v%0d short_n", idx), n_s, (v.e_short >= 0) ? 1 : 0);
        chk($sformatf("v%0d short_cyc", idx), c_s, v.e_short);
        chk($sformatf("v%0d dbl_n", idx), n_d, (v.e_dbl >= 0) ? 1 : 0);
        chk($sformatf("v%0d dbl_cyc", idx), c_d, v.e_dbl);
        chk($sformatf("v%0d long_n", idx), n_l, (v.e_long >= 0) ? 1 : 0);
        chk($sformatf("v%0d long_cyc", idx), c_l, v.e_long);
        chk($sformatf("v%0d rep_n", idx), n_r, v.e_rep_n);
        chk($sformatf("v%0d rep_first", idx), r_first, v.e_rep_first);
        chk($sformatf("v%0d rep_last", idx), r_last, v.e_rep_last);
        chk($sformatf("v%0d held_fall", idx), fall, v.e_fall);
        $display("vec %0d: short@%0d dbl@%0d long@%0d rep=%0d held_fall@%0d",
                 idx, c_s, c_d, c_l, n_r, fall);
    endtask

    vec_t vecs[8];

    initial begin
        //            c0 k0 c1 k1 c2 k2 c3 k3  len short dbl long repN repF repL fall
        vecs[0] = mk(0, 1, 10, 2,  0, 0,  0, 0, 40,  23, -1, -1, 0, -1, -1, 11);
        vecs[1] = mk(0, 1, 50, 2,  0, 0,  0, 0, 60,  -1, -1, 21, 3, 29, 45, 51);
        vecs[2] = mk(0, 1, 10, 2, 15, 1, 40, 2, 60,  -1, 41, -1, 0, -1, -1, 41);
        vecs[3] = mk(0, 1, 20, 2,  0, 0,  0, 0, 45,  33, -1, -1, 0, -1, -1, 21);
        vecs[4] = mk(0, 1, 10, 2, 22, 1, 30, 2, 45,  -1, 31, -1, 0, -1, -1, 31);
        vecs[5] = mk(0, 1,  8, 3,  0, 0,  0, 0, 30,  -1, -1, 21, 1, 29, 29, -1);
        vecs[6] = mk(0, 1,  5, 1, 10, 2, 12, 2, 40,  23, -1, -1, 0, -1, -1, 11);
        vecs[7] = mk(0, 1, 30, 1, 50, 2,  0, 0, 60,  -1, -1, 21, 3, 29, 45, 51);

        for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

        // Reset asserted mid-hold: outputs drop at once and the gesture is lost.
        begin
            int n_l, held14;
            n_l = 0; held14 = 0;
            do_reset();
            for (int c = 0; c < 40; c++) begin
                @(negedge clk);
                bus.key_p_flag = (c == 0);
                bus.key_r_flag = 1'b0;
                if (c == 14) held14 = int'(bus.key_held);
                if (c == 15) begin
                    rst_n = 1'b0;
                    #1;
                    chk("rst_async_outs", outs_word(), 0);
                end
                if (c == 17) rst_n = 1'b1;
                if (c > 15 && bus.long_press) n_l++;
            end
            chk("rst_held_before", held14, 1);
            chk("rst_no_long", n_l, 0);
            $display("reset mid-gesture: held before=%0d long after=%0d", held14, n_l);
        end

        // Both flags together in IDLE leave the decoder idle and ready for a press.
        begin
            int held_any, held7;
            held_any = 0; held7 = 0;
            do_reset();
            for (int c = 0; c < 10; c++) begin
                @(negedge clk);
                bus.key_p_flag = (c == 0) || (c == 6);
                bus.key_r_flag = (c == 0);
                if (c >= 1 && c <= 6 && bus.key_held) held_any++;
                if (c == 7) held7 = int'(bus.key_held);
            end
            chk("both_idle_held", held_any, 0);
            chk("both_idle_then_press", held7, 1);
            $display("both flags in IDLE: held cycles=%0d held after press=%0d", held_any, held7);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
